// File: rtl/uart_pkg.sv
// Shared types and constants for the arbitrated UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin selector: first valid requester searched from last_grant+1
// modulo NREQ; purely combinational.
module uart_rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  index,
   output logic            any
);

   // NOTE: every output gets a default before the search so no latch is inferred.
   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      // Outer loop is priority distance from the last winner; inner loop keeps selects constant.
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!any && valid[i] && (i == (int'(last_grant) + k) % NREQ)) begin
               any      = 1'b1;
               grant[i] = 1'b1;
               index    = IDW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// NREQ requesters share one UART transmit line through a round-robin arbiter.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NREQ       = 4,
   parameter  int OVERSAMPLE = 4,
   localparam int IDW        = $clog2(NREQ)
) (
   input  logic              bclk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              tx_data,
   output logic              busy,
   output logic [IDW-1:0]    grant_id
);

   localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = $clog2(DATA_BITS);

   state_t              state;
   state_t              state_next;
   logic [SW-1:0]       sample_cnt;
   logic [BW-1:0]       bit_cnt;
   logic [7:0]          data_q;
   logic [7:0]          sel_byte;
   logic [IDW-1:0]      last_grant;
   logic [NREQ-1:0]     win_onehot;
   logic [IDW-1:0]      win_idx;
   logic                win_any;
   logic                sample_last;
   logic                bit_last;
   logic                accept;

   uart_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .valid      (req_valid),
      .last_grant (last_grant),
      .grant      (win_onehot),
      .index      (win_idx),
      .any        (win_any)
   );

   assign sample_last = (sample_cnt == SW'(OVERSAMPLE - 1));
   assign bit_last    = (bit_cnt == BW'(DATA_BITS - 1));
   assign accept      = (state == IDLE) && win_any;

   always_comb begin
      sel_byte = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_onehot[i]) sel_byte = req_data[8*i +: 8];
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
   always_ff @(posedge bclk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      tx_data    = STOP_BIT;
      busy       = 1'b1;
      req_ready  = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            // Reset leaves the FSM in IDLE, so the accept must be gated explicitly.
            req_ready = reset ? '0 : win_onehot;
            if (win_any) state_next = START;
         end
         START: begin
            tx_data = START_BIT;
            if (sample_last) state_next = DATA;
         end
         DATA: begin
            tx_data = data_q[bit_cnt];
            if (sample_last && bit_last) begin
`ifdef UART_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_data = ^data_q;
            if (sample_last) state_next = STOP;
         end
`endif
         STOP: begin
            tx_data = STOP_BIT;
            if (sample_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge bclk or posedge reset) begin
      if (reset) begin
         sample_cnt <= '0;
         bit_cnt    <= '0;
         data_q     <= '0;
         grant_id   <= '0;
         last_grant <= IDW'(NREQ - 1);
      end else if (accept) begin
         data_q     <= sel_byte;
         grant_id   <= win_idx;
         last_grant <= win_idx;
         sample_cnt <= '0;
         bit_cnt    <= '0;
      end else if (state != IDLE) begin
         sample_cnt <= sample_last ? '0 : sample_cnt + SW'(1);
         if (state == DATA && sample_last) begin
            bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
         end
      end
   end

endmodule
